// File: rtl/alarm_register_file.sv
// Alarm register file: per-slot time word, armed flag and latched hit flag with Ack servicing.
// Optional snooze counters are built when ALARM_SNOOZE_EN is defined.
module alarm_register_file #(
    parameter int unsigned NUM_SLOTS    = 7,
    parameter int unsigned DATA_W       = 13,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned SNOOZE_TICKS = 5
) (
    input  logic                        Clock,
    input  logic                        Clear,
    input  logic                        Enable,
    input  logic [1:0]                  Op,
    input  logic [SEL_W-1:0]            STO,
    input  logic [DATA_W-1:0]           D,
    input  logic [DATA_W-1:0]           Time,
    input  logic                        Tick,
    input  logic                        Ack,
    input  logic                        Snooze,
    output logic [NUM_SLOTS*DATA_W-1:0] Q,
    output logic [NUM_SLOTS-1:0]        Armed,
    output logic [NUM_SLOTS-1:0]        Pending,
    output logic                        Ring,
    output logic [SEL_W-1:0]            Ring_slot
);

    typedef enum logic [1:0] {OpWrite, OpDisarm, OpArm, OpClear} op_e;

    op_e                  op;
    logic [DATA_W-1:0]    q_q [NUM_SLOTS];
    logic [DATA_W-1:0]    q_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] armed_q, armed_d;
    logic [NUM_SLOTS-1:0] pend_q, pend_d;
    logic [NUM_SLOTS-1:0] cmd_sel, hit, svc_sel, wake, kill;
    logic                 svc_clr;

    assign op = op_e'(Op);

    // Lowest pending index wins; assigning from the top down leaves the lowest last.
    always_comb begin
        Ring      = |pend_q;
        Ring_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pend_q[i]) Ring_slot = SEL_W'(i);
        end
    end

    // Out-of-range STO never matches any slot index, so such commands are dropped.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cmd_sel[i] = Enable && (STO == SEL_W'(i));
            hit[i]     = Tick && armed_q[i] && (q_q[i] == Time);
            svc_sel[i] = Ring && (Ring_slot == SEL_W'(i));
            kill[i]    = cmd_sel[i] && ((op == OpDisarm) || (op == OpClear));
        end
    end

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned CntW = (SNOOZE_TICKS < 1) ? 1 : $clog2(SNOOZE_TICKS + 1);

    logic [CntW-1:0] cnt_q [NUM_SLOTS];
    logic [CntW-1:0] cnt_d [NUM_SLOTS];

    assign svc_clr = Ack || Snooze;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt_d[i] = cnt_q[i];
            wake[i]  = Tick && (cnt_q[i] == CntW'(1));
            if (Tick && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - CntW'(1);
            if (Snooze && svc_sel[i]) cnt_d[i] = CntW'(SNOOZE_TICKS);
            if (kill[i]) cnt_d[i] = '0;
        end
    end

    always_ff @(posedge Clock) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (Clear) cnt_q[i] <= '0;
            else       cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic unused_snooze;

    assign unused_snooze = Snooze;
    assign svc_clr       = Ack;
    assign wake          = '0;
`endif

    // Per-slot priority: command disarm/clear > Tick set > Ack/Snooze clear.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            q_d[i]     = q_q[i];
            armed_d[i] = armed_q[i];
            pend_d[i]  = pend_q[i];
            if (svc_sel[i] && svc_clr) pend_d[i] = 1'b0;
            if (hit[i] || wake[i]) pend_d[i] = 1'b1;
            if (cmd_sel[i]) begin
                unique case (op)
                    OpWrite: begin
                        q_d[i]     = D;
                        armed_d[i] = 1'b1;
                    end
                    OpDisarm: begin
                        armed_d[i] = 1'b0;
                        pend_d[i]  = 1'b0;
                    end
                    OpArm: armed_d[i] = 1'b1;
                    OpClear: begin
                        q_d[i]     = '0;
                        armed_d[i] = 1'b0;
                        pend_d[i]  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            armed_q <= '0;
            pend_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) q_q[i] <= '0;
        end else begin
            armed_q <= armed_d;
            pend_q  <= pend_d;
            for (int i = 0; i < NUM_SLOTS; i++) q_q[i] <= q_d[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_q_out
        assign Q[g*DATA_W +: DATA_W] = q_q[g];
    end

    assign Armed   = armed_q;
    assign Pending = pend_q;

endmodule
